// File: rtl/mvm_pkg.sv
// mvm_pkg: shared state encoding, address/lane geometry and tile-index helper
// for the matrix-vector multiply controller.
package mvm_pkg;

   // Default WAIT-state budget before a tile is abandoned.
   localparam int MVM_TIMEOUT = 64;

   // Address widths of the vector and weight memories.
   localparam int VEC_AW = 8;
   localparam int WT_AW  = 12;

   // Array geometry: rows/columns per tile and the block-count field width.
   localparam int LANES = 4;
   localparam int BLK_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_WAIT = 3'd2,
      ST_ACC  = 3'd3,
      ST_OUT  = 3'd4,
      ST_FIN  = 3'd5
   } mvm_state_e;

   // Linear tile number of (row block rb, column block cb) in a grid that is
   // cblk column blocks wide; weights are stored tile after tile.
   function automatic logic [7:0] tile_index(input logic [3:0] rb,
                                             input logic [3:0] cblk,
                                             input logic [3:0] cb);
      logic [7:0] prod;
      prod = {4'd0, rb} * {4'd0, cblk};
      return prod + {4'd0, cb};
   endfunction

endpackage

// File: rtl/mvm_acc.sv
// mvm_acc: four wrapping row accumulators for one row block of the result.
// clr has priority over add_en so a block can be retired and restarted in
// the same cycle without leaking partial sums.
module mvm_acc
   import mvm_pkg::*;
#(
   parameter int OUTPUT_WIDTH = 64
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clr,
   input  logic                               add_en,
   input  logic [LANES-1:0][OUTPUT_WIDTH-1:0] add_in,
   output logic [LANES-1:0][OUTPUT_WIDTH-1:0] acc
);

   // Row sums: cleared on reset or clr, otherwise add the array rows modulo 2^OUTPUT_WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add_en) begin
         for (int i = 0; i < LANES; i++) begin
            acc[i] <= acc[i] + add_in[i];
         end
      end
   end

endmodule

// File: rtl/mvm_ctrl.sv
// mvm_ctrl: walks a blocked matrix-vector product tile by tile. Each tile
// streams four vector elements and four weight rows into the external array,
// waits for it to finish, and folds its row results into the accumulators.
// After the last column block of a row block the sums are offered to the sink.
module mvm_ctrl
   import mvm_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int OUTPUT_WIDTH = 64,
   parameter int TIMEOUT      = MVM_TIMEOUT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [BLK_W-1:0]            cmd_rblk,
   input  logic [BLK_W-1:0]            cmd_cblk,
   output logic [VEC_AW-1:0]           vec_addr,
   input  logic [DATA_WIDTH-1:0]       vec_data,
   output logic [WT_AW-1:0]            wt_addr,
   input  logic [LANES*DATA_WIDTH-1:0] wt_data,
   output logic                        mvm_start,
   output logic [1:0]                  mvm_data_sel,
   output logic [DATA_WIDTH-1:0]       mvm_data_in,
   output logic [DATA_WIDTH-1:0]       mvm_weight_1,
   output logic [DATA_WIDTH-1:0]       mvm_weight_2,
   output logic [DATA_WIDTH-1:0]       mvm_weight_3,
   output logic [DATA_WIDTH-1:0]       mvm_weight_4,
   input  logic [OUTPUT_WIDTH-1:0]     mvm_out1,
   input  logic [OUTPUT_WIDTH-1:0]     mvm_out2,
   input  logic [OUTPUT_WIDTH-1:0]     mvm_out3,
   input  logic [OUTPUT_WIDTH-1:0]     mvm_out4,
   input  logic                        mvm_done,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [OUTPUT_WIDTH-1:0]     res_0,
   output logic [OUTPUT_WIDTH-1:0]     res_1,
   output logic [OUTPUT_WIDTH-1:0]     res_2,
   output logic [OUTPUT_WIDTH-1:0]     res_3,
   output logic [BLK_W-1:0]            res_blk,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   // Last WAIT cycle index; mvm_done is still honoured on that cycle.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   mvm_state_e                        state_r;
   mvm_state_e                        state_s;
   logic [BLK_W-1:0]                  rblk_r;
   logic [BLK_W-1:0]                  cblk_r;
   logic [BLK_W-1:0]                  rb_r;
   logic [BLK_W-1:0]                  cb_r;
   logic [2:0]                        k_r;
   logic [15:0]                       wcnt_r;
   logic                              err_r;
   logic [BLK_W-1:0]                  last_rb_s;
   logic [BLK_W-1:0]                  last_cb_s;
   logic [7:0]                        tile_s;
   logic [1:0]                        k_sel_s;
   logic                              acc_clr_s;
   logic                              acc_add_s;
   logic [LANES-1:0][OUTPUT_WIDTH-1:0] acc_s;

   assign last_rb_s = rblk_r - 4'd1;
   assign last_cb_s = cblk_r - 4'd1;
   assign tile_s    = tile_index(rb_r, cblk_r, cb_r);
   // Data for address k arrives one cycle later, so the array slot lags k by one.
   assign k_sel_s   = k_r[1:0] - 2'd1;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               if ((cmd_rblk == 4'd0) || (cmd_cblk == 4'd0)) begin
                  state_s = ST_FIN;
               end else begin
                  state_s = ST_LOAD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (k_r == 3'd4) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_WAIT: begin
            if (mvm_done) begin
               state_s = ST_ACC;
            end else if (wcnt_r == WAIT_LAST) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_ACC: begin
            if (cb_r != last_cb_s) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_OUT;
            end
         end
         ST_OUT: begin
            if (!res_ready) begin
               state_s = ST_OUT;
            end else if (rb_r != last_rb_s) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_FIN;
            end
         end
         ST_FIN:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Block, load-step and wait counters plus the sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rblk_r <= 4'd0;
         cblk_r <= 4'd0;
         rb_r   <= 4'd0;
         cb_r   <= 4'd0;
         k_r    <= 3'd0;
         wcnt_r <= 16'd0;
         err_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  rblk_r <= cmd_rblk;
                  cblk_r <= cmd_cblk;
                  rb_r   <= 4'd0;
                  cb_r   <= 4'd0;
                  k_r    <= 3'd0;
                  err_r  <= 1'b0;
               end
            end
            ST_LOAD: begin
               wcnt_r <= 16'd0;
               if (k_r == 3'd4) begin
                  k_r <= 3'd0;
               end else begin
                  k_r <= k_r + 3'd1;
               end
            end
            ST_WAIT: begin
               wcnt_r <= wcnt_r + 16'd1;
               if (!mvm_done && (wcnt_r == WAIT_LAST)) begin
                  err_r <= 1'b1;
               end
            end
            ST_ACC: begin
               if (cb_r != last_cb_s) begin
                  cb_r <= cb_r + 4'd1;
               end
            end
            ST_OUT: begin
               if (res_ready) begin
                  cb_r <= 4'd0;
                  if (rb_r != last_rb_s) begin
                     rb_r <= rb_r + 4'd1;
                  end
               end
            end
            default: begin
               k_r <= 3'd0;
            end
         endcase
      end
   end

   // Accumulator control: clear on command accept and on result handshake, add in ACC.
   always_comb begin
      acc_clr_s = 1'b0;
      acc_add_s = 1'b0;
      case (state_r)
         ST_IDLE: acc_clr_s = cmd_valid;
         ST_ACC:  acc_add_s = 1'b1;
         ST_OUT:  acc_clr_s = res_ready;
         default: begin
            acc_clr_s = 1'b0;
            acc_add_s = 1'b0;
         end
      endcase
   end

   mvm_acc #(
      .OUTPUT_WIDTH (OUTPUT_WIDTH)
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr_s),
      .add_en (acc_add_s),
      .add_in ({mvm_out4, mvm_out3, mvm_out2, mvm_out1}),
      .acc    (acc_s)
   );

   // Output decode from the current state and counters.
   always_comb begin
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      vec_addr     = 8'd0;
      wt_addr      = 12'd0;
      mvm_start    = 1'b0;
      mvm_data_sel = 2'd0;
      mvm_data_in  = '0;
      mvm_weight_1 = '0;
      mvm_weight_2 = '0;
      mvm_weight_3 = '0;
      mvm_weight_4 = '0;
      res_valid    = 1'b0;
      res_0        = '0;
      res_1        = '0;
      res_2        = '0;
      res_3        = '0;
      res_blk      = 4'd0;
      done         = 1'b0;
      err          = err_r;
      case (state_r)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_LOAD: begin
            if (k_r != 3'd4) begin
               vec_addr = {2'b00, cb_r, k_r[1:0]};
               wt_addr  = {2'b00, tile_s, k_r[1:0]};
            end else begin
               vec_addr = 8'd0;
               wt_addr  = 12'd0;
            end
            if (k_r != 3'd0) begin
               mvm_start    = 1'b1;
               mvm_data_sel = k_sel_s;
               mvm_data_in  = vec_data;
               mvm_weight_1 = wt_data[DATA_WIDTH-1:0];
               mvm_weight_2 = wt_data[2*DATA_WIDTH-1:DATA_WIDTH];
               mvm_weight_3 = wt_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
               mvm_weight_4 = wt_data[4*DATA_WIDTH-1:3*DATA_WIDTH];
            end else begin
               mvm_start = 1'b0;
            end
         end
         ST_WAIT: mvm_start = 1'b1;
         ST_OUT: begin
            res_valid = 1'b1;
            res_0     = acc_s[0];
            res_1     = acc_s[1];
            res_2     = acc_s[2];
            res_3     = acc_s[3];
            res_blk   = rb_r;
         end
         ST_FIN:  done = 1'b1;
         default: busy = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mvm_ctrl.sv
// tb_mvm_ctrl: directed bench for mvm_ctrl with a stub array, registered
// vector/weight memories, a ready-throttling sink and a result scoreboard.
module tb_mvm_ctrl;

   localparam int DW = 32;
   localparam int OW = 64;

   typedef struct packed {
      logic [3:0]    blk;
      logic [OW-1:0] r0;
      logic [OW-1:0] r1;
      logic [OW-1:0] r2;
      logic [OW-1:0] r3;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [3:0]    cmd_rblk = 4'd0;
   logic [3:0]    cmd_cblk = 4'd0;
   logic [7:0]    vec_addr;
   logic [DW-1:0] vec_data = '0;
   logic [11:0]   wt_addr;
   logic [4*DW-1:0] wt_data = '0;
   logic          mvm_start;
   logic [1:0]    mvm_data_sel;
   logic [DW-1:0] mvm_data_in, mvm_weight_1, mvm_weight_2, mvm_weight_3, mvm_weight_4;
   logic [OW-1:0] mvm_out1, mvm_out2, mvm_out3, mvm_out4;
   logic          mvm_done;
   logic          res_valid;
   logic          res_ready = 1'b1;
   logic [OW-1:0] res_0, res_1, res_2, res_3;
   logic [3:0]    res_blk;
   logic          busy, done, err;

   // Bench state
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic [15:0]   sc = 16'd0;
   logic [15:0]   stub_lat = 16'd6;
   logic          spur_done = 1'b0;
   logic [OW-1:0] stub_out [4];
   logic [7:0]    last_vec = 8'd0;
   logic [11:0]   last_wt = 12'd0;
   int            ready_delay = 0;
   int            hold_cnt = 0;
   int            exp_vlen = 1;
   res_t          exp_q[$];
   logic [7:0]    vec_log[$];
   logic [11:0]   wt_log[$];
   int            res_cycles = 0, hs_cnt = 0, done_cnt = 0;
   int            acc_cyc = 0, hs_cyc = 0, done_cyc = 0, first_valid_cyc = 0;
   int            run = 0, last_run = 0;

   mvm_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rblk(cmd_rblk), .cmd_cblk(cmd_cblk), .vec_addr(vec_addr), .vec_data(vec_data),
      .wt_addr(wt_addr), .wt_data(wt_data), .mvm_start(mvm_start), .mvm_data_sel(mvm_data_sel),
      .mvm_data_in(mvm_data_in), .mvm_weight_1(mvm_weight_1), .mvm_weight_2(mvm_weight_2),
      .mvm_weight_3(mvm_weight_3), .mvm_weight_4(mvm_weight_4), .mvm_out1(mvm_out1),
      .mvm_out2(mvm_out2), .mvm_out3(mvm_out3), .mvm_out4(mvm_out4), .mvm_done(mvm_done),
      .res_valid(res_valid), .res_ready(res_ready), .res_0(res_0), .res_1(res_1),
      .res_2(res_2), .res_3(res_3), .res_blk(res_blk), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Weight lane n (0-based) stored at weight address a.
   function automatic logic [31:0] wlane(input logic [11:0] a, input int n);
      return (32'(a) << 4) + 32'(n + 1);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Stub array: mvm_done after stub_lat cycles of mvm_start; memories read with one cycle latency.
   assign mvm_done = (mvm_start && (sc >= stub_lat)) || spur_done;
   assign mvm_out1 = stub_out[0];
   assign mvm_out2 = stub_out[1];
   assign mvm_out3 = stub_out[2];
   assign mvm_out4 = stub_out[3];

   always @(posedge clk) begin
      vec_data <= 32'(vec_addr) + 32'd1;
      wt_data  <= {wlane(wt_addr, 3), wlane(wt_addr, 2), wlane(wt_addr, 1), wlane(wt_addr, 0)};
      last_vec <= vec_addr;
      last_wt  <= wt_addr;
      sc       <= mvm_start ? sc + 16'd1 : 16'd0;
      cyc      <= cyc + 1;
   end

   // Sink: hold res_ready low for ready_delay cycles of each presented block.
   initial forever begin
      @(posedge clk); #1;
      if (res_valid) begin
         if (hold_cnt < ready_delay) begin
            res_ready = 1'b0;
            hold_cnt++;
         end else begin
            res_ready = 1'b1;
         end
      end else begin
         hold_cnt  = 0;
         res_ready = 1'b1;
      end
   end

   // Load monitor: the array feed during LOAD steps k=1..4 (stub count 0..3).
   initial forever begin
      @(negedge clk);
      if (mvm_start && (sc < 16'd4)) begin
         chk("data_sel", 64'(mvm_data_sel), 64'(sc[1:0]));
         chk("data_in", 64'(mvm_data_in), 64'(32'(last_vec) + 32'd1));
         chk("weight_1", 64'(mvm_weight_1), 64'(wlane(last_wt, 0)));
         chk("weight_2", 64'(mvm_weight_2), 64'(wlane(last_wt, 1)));
         chk("weight_3", 64'(mvm_weight_3), 64'(wlane(last_wt, 2)));
         chk("weight_4", 64'(mvm_weight_4), 64'(wlane(last_wt, 3)));
         vec_log.push_back(last_vec);
         wt_log.push_back(last_wt);
      end
   end

   // Result monitor / scoreboard, plus done, accept and mvm_start-run bookkeeping.
   initial begin
      logic prev_valid, prev_hs, prev_done;
      res_t snap, e;
      prev_valid = 1'b0; prev_hs = 1'b0; prev_done = 1'b0; snap = '0;
      forever begin
         int vrun;
         @(negedge clk);
         if (res_valid) begin
            res_cycles++;
            if (!prev_valid || prev_hs) begin
               first_valid_cyc = cyc;
               vrun = 0;
            end else begin
               chk("hold_blk", 64'(res_blk), 64'(snap.blk));
               chk("hold_r0", res_0, snap.r0);
               chk("hold_r1", res_1, snap.r1);
               chk("hold_r2", res_2, snap.r2);
               chk("hold_r3", res_3, snap.r3);
            end
            vrun++;
            snap = '{blk: res_blk, r0: res_0, r1: res_1, r2: res_2, r3: res_3};
            if (res_ready) begin
               hs_cnt++;
               hs_cyc = cyc;
               chk("valid_len", 64'(vrun), 64'(exp_vlen));
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL res_unexpected: got blk %0d, expected no result", res_blk);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_blk", 64'(res_blk), 64'(e.blk));
                  chk("res_0", res_0, e.r0);
                  chk("res_1", res_1, e.r1);
                  chk("res_2", res_2, e.r2);
                  chk("res_3", res_3, e.r3);
               end
            end
         end
         prev_valid = res_valid;
         prev_hs    = res_valid && res_ready;
         if (done) begin
            chk("done_one_cycle", 64'(prev_done), 64'd0);
            done_cnt++;
            done_cyc = cyc;
         end
         prev_done = done;
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (mvm_start) run++;
         else begin
            if (run != 0) last_run = run;
            run = 0;
         end
      end
   end

   task automatic set_out(input logic [OW-1:0] a, b, c, d);
      stub_out[0] = a; stub_out[1] = b; stub_out[2] = c; stub_out[3] = d;
   endtask

   task automatic issue(input logic [3:0] r, input logic [3:0] c);
      vec_log.delete();
      wt_log.delete();
      @(posedge clk); #1;
      cmd_rblk = r; cmd_cblk = c; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int d0 = done_cnt;
      int n = 0;
      while ((done_cnt == d0) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == d0) begin
         n_cmp++; n_err++;
         $display("FAIL %s_no_done: got no done in %0d cycles, expected one", nm, budget);
      end
      @(negedge clk);
   endtask

   // Address streams against the tile walk: vec=cb*4+k, wt=(rb*cblk+cb)*4+k.
   task automatic check_logs(input string nm, input int r, input int c);
      int idx = 0;
      chk({nm, "_nloads"}, 64'(vec_log.size()), 64'(r * c * 4));
      for (int rb = 0; rb < r; rb++)
         for (int cb = 0; cb < c; cb++)
            for (int k = 0; k < 4; k++) begin
               if (idx < vec_log.size()) begin
                  chk({nm, "_vec_addr"}, 64'(vec_log[idx]), 64'(cb * 4 + k));
                  chk({nm, "_wt_addr"}, 64'(wt_log[idx]), 64'((rb * c + cb) * 4 + k));
               end
               idx++;
            end
   endtask

   task automatic chk_rst_outs(input string nm);
      chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      chk({nm, "_busy_done_err"}, 64'({busy, done, err, res_valid, mvm_start}), 64'd0);
      chk({nm, "_others"}, 64'({|vec_addr, |wt_addr, |mvm_data_sel, |mvm_data_in, |mvm_weight_1,
                                |mvm_weight_2, |mvm_weight_3, |mvm_weight_4, |res_0, |res_1,
                                |res_2, |res_3, |res_blk}), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0, h0, n;
      set_out(64'd0, 64'd0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      #1 chk_rst_outs("reset");
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // mvm_done while idle is ignored
      spur_done = 1'b1;
      repeat (2) @(posedge clk); #1;
      spur_done = 1'b0;
      chk("idle_spur_busy", 64'(busy), 64'd0);
      chk("idle_spur_res", 64'(res_cycles), 64'd0);

      // T1: single tile, 3 WAIT cycles
      stub_lat = 16'd6; ready_delay = 0; exp_vlen = 1;
      set_out(64'd10, 64'd20, 64'd30, 64'd40);
      exp_q.push_back('{blk: 4'd0, r0: 64'd10, r1: 64'd20, r2: 64'd30, r3: 64'd40});
      issue(4'd1, 4'd1);
      wait_done("t1", 200);
      chk("t1_tile_latency", 64'(first_valid_cyc - acc_cyc), 64'd10);
      chk("t1_done_after_hs", 64'(done_cyc - hs_cyc), 64'd1);
      check_logs("t1", 1, 1);

      // T2: two column blocks summed; commands while busy are refused
      set_out(64'd5, 64'd5, 64'd5, 64'd5);
      exp_q.push_back('{blk: 4'd0, r0: 64'd10, r1: 64'd10, r2: 64'd10, r3: 64'd10});
      h0 = hs_cnt;
      issue(4'd1, 4'd2);
      cmd_rblk = 4'd3; cmd_cblk = 4'd3; cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
      wait_done("t2", 300);
      chk("t2_blocks", 64'(hs_cnt - h0), 64'd1);
      check_logs("t2", 1, 2);

      // T3: two row blocks, sink stalls 7 cycles each, spurious mvm_done while OUT
      ready_delay = 7; exp_vlen = 8;
      set_out(64'd7, 64'd8, 64'd9, 64'd11);
      exp_q.push_back('{blk: 4'd0, r0: 64'd7, r1: 64'd8, r2: 64'd9, r3: 64'd11});
      exp_q.push_back('{blk: 4'd1, r0: 64'd7, r1: 64'd8, r2: 64'd9, r3: 64'd11});
      h0 = hs_cnt;
      issue(4'd2, 4'd1);
      n = 0;
      while (!res_valid && (n < 100)) begin @(negedge clk); n++; end
      chk("t3_valid_seen", 64'(res_valid), 64'd1);
      @(posedge clk); #1 spur_done = 1'b1;
      @(posedge clk); #1 spur_done = 1'b0;
      wait_done("t3", 400);
      chk("t3_blocks", 64'(hs_cnt - h0), 64'd2);
      check_logs("t3", 2, 1);

      // T7: 2x2 grid with wrapping sums
      ready_delay = 0; exp_vlen = 1;
      set_out(64'h8000_0000_0000_0001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4);
      exp_q.push_back('{blk: 4'd0, r0: 64'd2, r1: 64'd6, r2: 64'hFFFF_FFFF_FFFF_FFFE, r3: 64'd8});
      exp_q.push_back('{blk: 4'd1, r0: 64'd2, r1: 64'd6, r2: 64'hFFFF_FFFF_FFFF_FFFE, r3: 64'd8});
      issue(4'd2, 4'd2);
      wait_done("t7", 600);
      check_logs("t7", 2, 2);

      // T4: array never finishes -> timeout
      stub_lat = 16'hFFFF;
      d0 = done_cnt;
      issue(4'd1, 4'd1);
      n = 0;
      while (!err && (n < 200)) begin @(negedge clk); n++; end
      @(negedge clk);
      chk("to_err", 64'(err), 64'd1);
      chk("to_mvm_start", 64'(mvm_start), 64'd0);
      chk("to_busy", 64'(busy), 64'd0);
      chk("to_start_cycles", 64'(last_run), 64'd68);
      chk("to_no_done", 64'(done_cnt - d0), 64'd0);
      repeat (5) @(negedge clk);
      chk("to_err_sticky", 64'(err), 64'd1);

      // T5: zero block counts finish at once and clear err
      r0 = res_cycles;
      issue(4'd1, 4'd0);
      chk("zero_err_cleared", 64'(err), 64'd0);
      wait_done("zc", 20);
      chk("zc_done_latency", 64'(done_cyc - acc_cyc), 64'd1);
      issue(4'd0, 4'd3);
      wait_done("zr", 20);
      chk("zr_done_latency", 64'(done_cyc - acc_cyc), 64'd1);
      chk("zero_no_res", 64'(res_cycles - r0), 64'd0);

      // T6: reset during WAIT, then a normal command
      d0 = done_cnt; r0 = res_cycles;
      issue(4'd1, 4'd1);
      n = 0;
      while ((sc < 16'd6) && (n < 50)) begin @(negedge clk); n++; end
      chk("t6_in_wait", 64'(mvm_start), 64'd1);
      @(negedge clk); rst = 1'b1;
      #1 chk_rst_outs("rst_async");
      repeat (2) @(posedge clk);
      #1 chk_rst_outs("rst_held");
      @(negedge clk); rst = 1'b0;
      chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
      chk("t6_no_res", 64'(res_cycles - r0), 64'd0);
      stub_lat = 16'd6;
      set_out(64'd10, 64'd20, 64'd30, 64'd40);
      exp_q.push_back('{blk: 4'd0, r0: 64'd10, r1: 64'd20, r2: 64'd30, r3: 64'd40});
      issue(4'd1, 4'd1);
      wait_done("t6", 200);
      check_logs("t6", 1, 1);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mvm_ctrl.md
MVM_CTRL -- requirements
Module: mvm_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand and weight width.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 64, meaning array-result and accumulator width.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning maximum number of WAIT cycles before abort.
REQ-004 Ports, in order: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the controller accepts a command.
- cmd_rblk  in  4  number of 4-row blocks.
- cmd_cblk  in  4  number of 4-column blocks.
- vec_addr  out  8  input-vector read address.
- vec_data  in  DATA_WIDTH  vector element; valid 1 cycle after vec_addr.
- wt_addr  out  12  weight read address.
- wt_data  in  4*DATA_WIDTH  four weights, [DATA_WIDTH-1:0]=weight_1; valid 1 cycle after wt_addr.
- mvm_start, mvm_data_sel[1:0], mvm_data_in, mvm_weight_1..4  out  array drive.
- mvm_out1..4  in  OUTPUT_WIDTH  array row results.
- mvm_done  in  1  array completion.
- res_valid  out  1  a result block is presented.
- res_ready  in  1  the sink accepts the result block.
- res_0..3  out  OUTPUT_WIDTH  accumulated row sums.
- res_blk  out  4  row-block index of the result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at command end.
- err  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement the states IDLE, LOAD, WAIT, ACC, OUT, FIN.
REQ-006 IDLE: cmd_ready=1; cmd_valid&&cmd_ready SHALL latch rblk and cblk, set rb=cb=0 and clear the accumulators.
- Either count zero: go to FIN, emitting no results.
- Otherwise: go to LOAD.
REQ-007 LOAD SHALL last 5 cycles, k=0..4.
- For k<4: issue vec_addr=cb*4+k and wt_addr=(rb*cblk+cb)*4+k.
- For k>=1: drive mvm_data_sel=k-1, mvm_data_in=vec_data, mvm_weight_n=wt_data lanes.
- mvm_start=1 from k=1 until WAIT exits.
REQ-008 WAIT SHALL hold mvm_start=1 until mvm_done=1, then go to ACC.
- If TIMEOUT cycles elapse without mvm_done: set err, drop mvm_start, go to IDLE without a done pulse.
REQ-009 ACC (1 cycle): acc_n += mvm_outn, wrapping modulo 2^OUTPUT_WIDTH; mvm_start=0.
- cb<cblk-1: cb++, go to LOAD.
- Otherwise: go to OUT.
REQ-010 OUT: res_valid=1 with res_n=acc_n and res_blk=rb; the outputs SHALL stay stable until res_ready.
- On handshake: clear the accumulators and set cb=0.
- rb<rblk-1: rb++, go to LOAD.
- Otherwise: go to FIN.
REQ-011 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-012 cmd_valid outside IDLE SHALL be ignored; cmd_ready=0 in those states.
REQ-013 res_ready=1 while res_valid=0 SHALL have no effect.
REQ-014 mvm_done arriving in any state other than WAIT SHALL be ignored.
REQ-015 err SHALL clear only on reset or on acceptance of the next command.
REQ-016 Latency per tile SHALL be 5 + W + 1 cycles, where W is the number of WAIT cycles.

Reset
REQ-017 While rst=1, and asynchronously, the controller SHALL:
- enter IDLE;
- clear all counters and accumulators;
- drive cmd_ready=1 and every other output to 0.
REQ-018 Reset mid-operation SHALL abort with no done pulse and no res_valid.

Structure
REQ-019 Package mvm_pkg SHALL hold:
- the state enumeration;
- TIMEOUT;
- the address widths (8 and 12);
- the lane count (4).
REQ-020 Sub-module mvm_acc SHALL hold the four OUTPUT_WIDTH accumulators, with add-enable and clear inputs.

Verification
REQ-021 rblk=1, cblk=1, vec=1,2,3,4, stub array returns 10,20,30,40 after 3 WAIT cycles -> res=10,20,30,40, res_blk=0, done 1 cycle after the res handshake.
REQ-022 rblk=1, cblk=2, stub returns 5 per row each tile -> one result block of 10,10,10,10; vec_addr sequence 0..7 observed.
REQ-023 rblk=2, cblk=1, res_ready held low for 7 cycles -> res_valid and res_0..3 stable for all 8 cycles; second block carries res_blk=1.
REQ-024 mvm_done never asserted -> err=1 after 64 WAIT cycles, mvm_start=0, IDLE reached, no done pulse.
REQ-025 cmd_cblk=0 -> done one cycle after acceptance, res_valid never high.
REQ-026 rst pulsed during WAIT -> all outputs 0 except cmd_ready=1; a following command completes normally.
